// File: rtl/uart_core_rx_if.sv
// Signal bundle for uart_core_rx: line, enable, frame configuration and received-word outputs.
// master drives the line and configuration; slave is the receiver.
interface uart_core_rx_if #(
    parameter int BAUD_DIV_WIDTH = 8
);
    logic [BAUD_DIV_WIDTH-1:0] baud_div;
    logic [1:0]                data_type;
    logic                      check_en;
    logic [1:0]                check_type;
    logic                      en;
    logic                      rx;
    logic [7:0]                data;
    logic                      ack;
    logic                      busy;
    logic                      check_err;
    logic                      frame_err;

    modport master (
        output baud_div, data_type, check_en, check_type, en, rx,
        input  data, ack, busy, check_err, frame_err
    );

    modport slave (
        input  baud_div, data_type, check_en, check_type, en, rx,
        output data, ack, busy, check_err, frame_err
    );
endinterface

// File: rtl/uart_core_rx.sv
// UART receiver: 8x oversampling, majority vote per bit, 5..8 data bits,
// optional parity, single stop bit, break detection with re-arm on line idle.
module uart_core_rx #(
    parameter int CLK_FREQ       = 100,
    parameter int BAUD_DIV_WIDTH = 8
) (
    input logic          clk,
    input logic          rst_n,
    uart_core_rx_if.slave bus
);
    localparam int CLK_DIV = CLK_FREQ / 10;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] CHECK = 3'd3;
    localparam logic [2:0] STOP  = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    logic [2:0]                state;
    logic                      rx_s1, rx_s2, rx_d;
    logic                      armed;
    logic                      edge_hold;
    logic [DIV_W-1:0]          div_cnt;
    logic [BAUD_DIV_WIDTH-1:0] baud_cnt;
    logic [2:0]                idx;
    logic                      s3, s4;
    logic [7:0]                sh;
    logic [2:0]                bit_cnt;
    logic                      chk_p;
    logic [7:0]                data_r;
    logic                      check_err_r, frame_err_r;

    logic       fall, start_det, div_last, baud_last, tick, samp, bit_val, par, perr;
    logic [2:0] last_idx;
    logic [7:0] data_now;

    always_comb begin
        fall      = rx_d & ~rx_s2;
        // an edge seen during the DONE cycle is remembered for one cycle so IDLE can still start on it
        start_det = (state == IDLE) && bus.en && armed && (fall || edge_hold);
        div_last  = (div_cnt == DIV_W'(CLK_DIV - 1));
        baud_last = (baud_cnt >= bus.baud_div);
        tick      = div_last && baud_last;
        samp      = tick && (idx == 3'd5);
        bit_val   = (s3 & s4) | (s3 & rx_s2) | (s4 & rx_s2);
        last_idx  = {1'b1, ~bus.data_type};
        data_now  = sh >> bus.data_type;
        par       = (^sh) ^ bit_val;
        perr      = 1'b0;
        case (bus.check_type)
            2'b00:   perr = ~par;
            2'b01:   perr = par;
            2'b10:   perr = ~bit_val;
            default: perr = bit_val;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            rx_s1       <= 1'b1;
            rx_s2       <= 1'b1;
            rx_d        <= 1'b1;
            armed       <= 1'b1;
            edge_hold   <= 1'b0;
            div_cnt     <= '0;
            baud_cnt    <= '0;
            idx         <= '0;
            s3          <= 1'b1;
            s4          <= 1'b1;
            sh          <= '0;
            bit_cnt     <= '0;
            chk_p       <= 1'b0;
            data_r      <= '0;
            check_err_r <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            rx_s1     <= bus.rx;
            rx_s2     <= rx_s1;
            rx_d      <= rx_s2;
            edge_hold <= (state == DONE) && fall;

            if (start_det) begin
                div_cnt  <= '0;
                baud_cnt <= '0;
                idx      <= '0;
            end else if (div_last) begin
                div_cnt <= '0;
                if (baud_last) begin
                    baud_cnt <= '0;
                    idx      <= idx + 3'd1;
                end else begin
                    baud_cnt <= baud_cnt + 1'b1;
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            if (tick && idx == 3'd3) s3 <= rx_s2;
            if (tick && idx == 3'd4) s4 <= rx_s2;

            if (state != IDLE && !bus.en) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (rx_s2) armed <= 1'b1;
                        if (start_det) begin
                            state   <= START;
                            sh      <= '0;
                            bit_cnt <= '0;
                            chk_p   <= 1'b0;
                        end
                    end
                    START: if (samp) state <= bit_val ? IDLE : DATA;
                    DATA: if (samp) begin
                        sh      <= {bit_val, sh[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == last_idx) state <= bus.check_en ? CHECK : STOP;
                    end
                    CHECK: if (samp) begin
                        chk_p <= perr;
                        state <= STOP;
                    end
                    STOP: if (samp) begin
                        data_r      <= data_now;
                        check_err_r <= bus.check_en & chk_p;
                        frame_err_r <= ~bit_val;
                        // a low stop with all-zero data is a break: stay deaf until the line idles high
                        if (!bit_val && data_now == 8'h00) armed <= 1'b0;
                        state <= DONE;
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.ack       = (state == DONE);
    assign bus.busy      = (state == DATA) || (state == CHECK) || (state == STOP);
    assign bus.data      = data_r;
    assign bus.check_err = check_err_r;
    assign bus.frame_err = frame_err_r;
endmodule

// File: tb/tb_uart_core_rx.sv
// Bench for uart_core_rx: directed scenarios plus randomized frames checked
// against a frame-level expectation queue.
module tb_uart_core_rx;
    localparam int CLK_FREQ = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_core_rx_if #(.BAUD_DIV_WIDTH(8)) u_if ();

    uart_core_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_DIV_WIDTH(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (u_if.slave)
    );

    typedef struct {
        logic [7:0] d;
        logic       ce;
        logic       fe;
    } exp_t;

    exp_t       q[$];
    exp_t       mon_e;
    int         total = 0;
    int         bad = 0;
    int         acks = 0;
    int         busy_run = 0;
    int         last_busy = 0;
    int         bit_clk = 80;
    logic [7:0] last_data = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (u_if.busy) busy_run++;
        else if (busy_run != 0) begin
            last_busy = busy_run;
            busy_run  = 0;
        end
        if (rst_n && u_if.ack) begin
            acks++;
            if (q.size() == 0) chk("unexp_ack", 1, 0);
            else begin
                mon_e = q.pop_front();
                chk("data", {24'h0, u_if.data}, {24'h0, mon_e.d});
                chk("check_err", {31'h0, u_if.check_err}, {31'h0, mon_e.ce});
                chk("frame_err", {31'h0, u_if.frame_err}, {31'h0, mon_e.fe});
                last_data = mon_e.d;
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic v);
        u_if.rx = v;
        wait_clk(bit_clk);
    endtask

    task automatic set_cfg(input logic [1:0] dt, input logic ce, input logic [1:0] ct, input logic [7:0] bd);
        u_if.data_type  = dt;
        u_if.check_en   = ce;
        u_if.check_type = ct;
        u_if.baud_div   = bd;
        bit_clk = (CLK_FREQ / 10) * (int'(bd) + 1) * 8;
    endtask

    // parity bit a correct transmitter would send for data d under check type ct
    function automatic logic good_par(input logic [7:0] d, input logic [1:0] ct);
        int ones = $countones(d);
        case (ct)
            2'b00:   return (ones % 2) == 0;
            2'b01:   return (ones % 2) == 1;
            2'b10:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic pb, input logic stopv);
        exp_t       e;
        int         nb = 8 - int'(u_if.data_type);
        logic [7:0] dm = d & (8'hFF >> u_if.data_type);
        e.d  = dm;
        e.ce = u_if.check_en && (pb != good_par(dm, u_if.check_type));
        e.fe = !stopv;
        q.push_back(e);
        send_bit(1'b0);
        for (int i = 0; i < nb; i++) send_bit(dm[i]);
        if (u_if.check_en) send_bit(pb);
        send_bit(stopv);
    endtask

    task automatic start_partial(input logic [7:0] d, input int nbits);
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) send_bit(d[i]);
        u_if.rx = d[nbits];
        wait_clk(bit_clk / 2);
    endtask

    int         a0, a1;
    logic [7:0] rd;
    logic [1:0] rdt, rct;
    logic       rce, rpb, rstop;

    initial begin
        u_if.rx = 1'b1;
        u_if.en = 1'b1;
        set_cfg(2'b00, 1'b0, 2'b00, 8'd0);
        rst_n = 1'b0;
        wait_clk(5);
        chk("rst_data", {24'h0, u_if.data}, 32'h0);
        chk("rst_ack", {31'h0, u_if.ack}, 32'h0);
        chk("rst_busy", {31'h0, u_if.busy}, 32'h0);
        chk("rst_check_err", {31'h0, u_if.check_err}, 32'h0);
        chk("rst_frame_err", {31'h0, u_if.frame_err}, 32'h0);
        rst_n = 1'b1;
        wait_clk(20);

        // 8N1 0xA5
        fork
            send_frame(8'hA5, 1'b0, 1'b1);
            begin
                wait_clk(bit_clk * 3);
                chk("a5_busy_mid", {31'h0, u_if.busy}, 32'h1);
            end
        join
        wait_clk(bit_clk);
        chk("a5_acks", acks, 1);
        chk("a5_busy_end", {31'h0, u_if.busy}, 32'h0);
        chk("a5_busy_len", {31'h0, (last_busy >= 680 && last_busy <= 800)}, 32'h1);

        // 7E1 0x41 with bad then good parity
        set_cfg(2'b01, 1'b1, 2'b01, 8'd0);
        send_frame(8'h41, 1'b1, 1'b1);
        wait_clk(bit_clk);
        send_frame(8'h41, 1'b0, 1'b1);
        wait_clk(bit_clk);
        chk("7e1_acks", acks, 3);

        // 30-clock glitch, then 0x3C
        set_cfg(2'b00, 1'b0, 2'b00, 8'd0);
        a0 = acks;
        u_if.rx = 1'b0;
        wait_clk(30);
        u_if.rx = 1'b1;
        wait_clk(bit_clk * 2);
        chk("glitch_noack", acks, a0);
        chk("glitch_busy", {31'h0, u_if.busy}, 32'h0);
        send_frame(8'h3C, 1'b0, 1'b1);
        wait_clk(bit_clk);

        // break: 0x00 with low stop, line held low, then 0x55
        a0 = acks;
        send_frame(8'h00, 1'b0, 1'b0);
        a1 = acks;
        wait_clk(bit_clk * 20);
        chk("break_ack", a1 - a0, 1);
        chk("break_quiet", acks, a1);
        chk("break_hold_fe", {31'h0, u_if.frame_err}, 32'h1);
        u_if.rx = 1'b1;
        wait_clk(bit_clk * 2);
        send_frame(8'h55, 1'b0, 1'b1);
        wait_clk(bit_clk);

        // reset during data bit 4
        a0 = acks;
        start_partial(8'hF0, 4);
        chk("rst_abort_busy_pre", {31'h0, u_if.busy}, 32'h1);
        rst_n = 1'b0;
        u_if.rx = 1'b1;
        wait_clk(1);
        chk("rst_abort_busy", {31'h0, u_if.busy}, 32'h0);
        chk("rst_abort_data", {24'h0, u_if.data}, 32'h0);
        last_data = 8'h00;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(bit_clk);
        chk("rst_abort_noack", acks, a0);
        send_frame(8'h96, 1'b0, 1'b1);
        wait_clk(bit_clk);

        // en dropped during data bit 2
        a0 = acks;
        start_partial(8'h0D, 2);
        chk("en_abort_busy_pre", {31'h0, u_if.busy}, 32'h1);
        u_if.en = 1'b0;
        u_if.rx = 1'b1;
        wait_clk(1);
        chk("en_abort_busy", {31'h0, u_if.busy}, 32'h0);
        chk("en_abort_hold", {24'h0, u_if.data}, {24'h0, last_data});
        wait_clk(bit_clk * 2);
        u_if.en = 1'b1;
        wait_clk(bit_clk);
        chk("en_abort_noack", acks, a0);
        send_frame(8'hC3, 1'b0, 1'b1);
        wait_clk(bit_clk);

        // back-to-back 5O1
        set_cfg(2'b11, 1'b1, 2'b00, 8'd0);
        a0 = acks;
        send_frame(8'h1F, good_par(8'h1F, 2'b00), 1'b1);
        send_frame(8'h0A, good_par(8'h0A, 2'b00), 1'b1);
        wait_clk(bit_clk * 2);
        chk("b2b_acks", acks - a0, 2);

        // randomized frames
        for (int n = 0; n < 16; n++) begin
            rdt = 2'($urandom_range(3));
            rce = 1'($urandom_range(1));
            rct = 2'($urandom_range(3));
            rd  = 8'($urandom);
            set_cfg(rdt, rce, rct, 8'($urandom_range(1)));
            rpb   = good_par(rd & (8'hFF >> rdt), rct) ^ ($urandom_range(3) == 0);
            rstop = ($urandom_range(7) != 0);
            send_frame(rd, rpb, rstop);
            u_if.rx = 1'b1;
            wait_clk(bit_clk * (1 + $urandom_range(1)));
        end

        wait_clk(bit_clk * 2);
        chk("pending", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
